// File: rtl/dmem_rmw_ctrl_pkg.sv
// Shared size encodings and controller state codes for the data-memory RMW controller.
// Pure definitions: no latency, no flow control.
package dmem_rmw_ctrl_pkg;

  localparam logic [1:0] FMT_WORD = 2'b00;
  localparam logic [1:0] FMT_HALF = 2'b01;
  localparam logic [1:0] FMT_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_MERGE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Encoding 11 has no size of its own and behaves exactly like a word access.
  function automatic logic [1:0] norm_fmt(input logic [1:0] fmt);
    return (fmt == 2'b11) ? FMT_WORD : fmt;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: write and read share one address; rdata is registered (1-cycle latency).
// Never stalls; contents are deliberately not reset.
module dmem_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    r_rdata <= r_mem[addr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// CPU data-port controller over a word RAM; byte/half stores become read-modify-write.
// Latency word-wr 1 / rd 2 / sub-word wr 3 edges; 4-phase ready handshake, ready held until request drops.
module dmem_rmw_ctrl
  import dmem_rmw_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          ADDR_W    = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_r,
  input  logic        dmem_w,
  input  logic [1:0]  store_format_signal,
  input  logic [31:0] data_addr,
  input  logic [31:0] w_data,
  output logic [31:0] dmem_data,
  output logic        ready,
  output logic        addr_err
);

  localparam logic [31:0] SPAN = 32'd4 << ADDR_W;

  state_t            r_state;
  logic              r_wr;
  logic [1:0]        r_fmt;
  logic [1:0]        r_lane;
  logic [ADDR_W-1:0] r_idx;
  logic [15:0]       r_wdat;
  logic              r_ready;
  logic              r_err;
  logic [31:0]       r_data;

  logic              w_req;
  logic [1:0]        w_fmt;
  logic [31:0]       w_off;
  logic [1:0]        w_lane;
  logic [ADDR_W-1:0] w_idx;
  logic              w_err;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_idx;
  logic [31:0]       w_ram_wdat;
  logic [31:0]       w_ram_rdat;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  assign w_req  = dmem_r | dmem_w;
  assign w_fmt  = norm_fmt(store_format_signal);
  assign w_off  = data_addr - BASE_ADDR;
  assign w_lane = w_off[1:0];
  assign w_idx  = w_off[ADDR_W+1:2];
  assign w_err  = (data_addr < BASE_ADDR) || (w_off >= SPAN) ||
                  ((w_fmt == FMT_WORD) && (w_lane != 2'd0)) ||
                  ((w_fmt == FMT_HALF) && w_lane[0]);

  // In IDLE the RAM sees the live request so a read or word write starts on the accept edge.
  assign w_ram_idx  = (r_state == ST_IDLE) ? w_idx : r_idx;
  assign w_ram_wdat = (r_state == ST_MERGE) ? w_merged : w_data;
  assign w_ram_we   = !rst &&
                      (((r_state == ST_IDLE) && dmem_w && (w_fmt == FMT_WORD) && !w_err) ||
                       (r_state == ST_MERGE));

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_idx),
    .wdata (w_ram_wdat),
    .rdata (w_ram_rdat)
  );

  always_comb begin
    w_load = w_ram_rdat;
    case (r_fmt)
      FMT_HALF: w_load = {16'h0, w_ram_rdat[{r_lane[1], 4'b0000} +: 16]};
      FMT_BYTE: w_load = {24'h0, w_ram_rdat[{r_lane, 3'b000} +: 8]};
      default:  w_load = w_ram_rdat;
    endcase
  end

  // RAM re-reads the same word in RD, so rdata still holds the old word during MERGE.
  always_comb begin
    w_merged = w_ram_rdat;
    case (r_fmt)
      FMT_HALF: w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdat;
      FMT_BYTE: w_merged[{r_lane, 3'b000} +: 8]      = r_wdat[7:0];
      default:  w_merged = w_ram_rdat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= 32'h0;
      r_wr    <= 1'b0;
      r_fmt   <= FMT_WORD;
      r_lane  <= 2'd0;
      r_idx   <= '0;
      r_wdat  <= 16'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_wr   <= dmem_w;
            r_fmt  <= w_fmt;
            r_lane <= w_lane;
            r_idx  <= w_idx;
            r_wdat <= w_data[15:0];
            if (w_err) begin
              r_state <= ST_DONE;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
            end else if (dmem_w && (w_fmt == FMT_WORD)) begin
              r_state <= ST_DONE;
              r_ready <= 1'b1;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (r_wr) begin
            r_state <= ST_MERGE;
          end else begin
            r_data  <= w_load;
            r_state <= ST_DONE;
            r_ready <= 1'b1;
          end
        end
        ST_MERGE: begin
          r_state <= ST_DONE;
          r_ready <= 1'b1;
        end
        ST_DONE: begin
          if (!dmem_r && !dmem_w) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dmem_data = r_data;
  assign ready     = r_ready;
  assign addr_err  = r_err;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Self-checking bench for dmem_rmw_ctrl: directed scenarios plus a randomized run against a word-array model.
module tb_dmem_rmw_ctrl;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_r;
  logic        dmem_w;
  logic [1:0]  fmt;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] dmem_data;
  logic        ready;
  logic        addr_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_rmw_ctrl #(.BASE_ADDR(BASE), .ADDR_W(11)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .dmem_r              (dmem_r),
    .dmem_w              (dmem_w),
    .store_format_signal (fmt),
    .data_addr           (addr),
    .w_data              (wd),
    .dmem_data           (dmem_data),
    .ready               (ready),
    .addr_err            (addr_err)
  );

  // Expected load value: the addressed byte/half shifted down to bit 0, zero-padded.
  function automatic logic [31:0] ref_load(input logic [31:0] wv, input int fn, input int lane);
    if (fn == 1) return (wv >> (8 * lane)) & 32'h0000_FFFF;
    if (fn == 2) return (wv >> (8 * lane)) & 32'h0000_00FF;
    return wv;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input int fn, input int lane,
                                            input logic [31:0] d);
    logic [31:0] mask;
    if (fn == 0) return d;
    mask = ((fn == 1) ? 32'h0000_FFFF : 32'h0000_00FF) << (8 * lane);
    return (old & ~mask) | ((d << (8 * lane)) & mask);
  endfunction

  task automatic drive(input bit r, input bit w, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    dmem_r = r; dmem_w = w; fmt = f; addr = a; wd = d;
  endtask

  // Edges counted from the accept edge (first posedge after drive) until ready is seen.
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_req();
    dmem_r = 1'b0; dmem_w = 1'b0;
    addr = $urandom; wd = $urandom; fmt = 2'($urandom);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic access(input bit r, input bit w, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic err,
                        output logic [31:0] q);
    drive(r, w, f, a, d);
    wait_ready(lat);
    err = addr_err;
    q   = dmem_data;
    release_req();
  endtask

  task automatic test_reset();
    rst = 1'b1; dmem_r = 1'b0; dmem_w = 1'b0; fmt = 2'b00; addr = BASE; wd = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", addr_err); end
    n_checks++; if (dmem_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", dmem_data); end
    rst = 1'b0;
  endtask

  task automatic test_word();
    int lat; logic err; logic [31:0] q;
    access(0, 1, 2'b00, 32'h1001_0008, 32'hDEAD_BEEF, lat, err, q);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL word_wr_lat: got %0d want 1", lat); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL word_wr_err: got %b want 0", err); end
    access(1, 0, 2'b00, 32'h1001_0008, 32'h0, lat, err, q);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL word_rd_lat: got %0d want 2", lat); end
    n_checks++; if (q !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_rd_data: got %h want deadbeef", q); end
  endtask

  task automatic test_byte_rmw();
    int lat; logic err; logic [31:0] q;
    access(0, 1, 2'b00, 32'h1001_0010, 32'h1122_3344, lat, err, q);
    access(0, 1, 2'b10, 32'h1001_0011, 32'h5A5A_C3AB, lat, err, q);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL byte_wr_lat: got %0d want 3", lat); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL byte_wr_err: got %b want 0", err); end
    access(1, 0, 2'b00, 32'h1001_0010, 32'h0, lat, err, q);
    n_checks++; if (q !== 32'h1122_AB44) begin n_fail++; $display("FAIL byte_rmw_word: got %h want 1122ab44", q); end
    access(1, 0, 2'b10, 32'h1001_0013, 32'h0, lat, err, q);
    n_checks++; if (q !== 32'h0000_0011) begin n_fail++; $display("FAIL byte_rd: got %h want 00000011", q); end
  endtask

  task automatic test_half_rmw();
    int lat; logic err; logic [31:0] q;
    access(0, 1, 2'b00, 32'h1001_0010, 32'hFFFF_FFFF, lat, err, q);
    access(0, 1, 2'b01, 32'h1001_0012, 32'hCAFE_1234, lat, err, q);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL half_wr_lat: got %0d want 3", lat); end
    access(1, 0, 2'b00, 32'h1001_0010, 32'h0, lat, err, q);
    n_checks++; if (q !== 32'h1234_FFFF) begin n_fail++; $display("FAIL half_rmw_word: got %h want 1234ffff", q); end
    access(1, 0, 2'b01, 32'h1001_0010, 32'h0, lat, err, q);
    n_checks++; if (q !== 32'h0000_FFFF) begin n_fail++; $display("FAIL half_rd: got %h want 0000ffff", q); end
  endtask

  task automatic test_errors();
    int lat; logic err; logic [31:0] q;
    access(0, 1, 2'b00, BASE, 32'hA5A5_A5A5, lat, err, q);
    access(0, 1, 2'b00, BASE + 32'h2, 32'h0BAD_0BAD, lat, err, q);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL misalign_word_err: got %b want 1", err); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL misalign_word_lat: got %0d want 1", lat); end
    access(1, 0, 2'b00, BASE, 32'h0, lat, err, q);
    n_checks++; if (q !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL misalign_no_write: got %h want a5a5a5a5", q); end
    access(1, 0, 2'b00, 32'h1000_FFFC, 32'h0, lat, err, q);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL below_base_err: got %b want 1", err); end
    n_checks++; if (q !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL err_data_hold: got %h want a5a5a5a5", q); end
    access(1, 0, 2'b00, BASE + 32'h2000, 32'h0, lat, err, q);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL past_top_err: got %b want 1", err); end
    access(1, 0, 2'b01, BASE + 32'h1, 32'h0, lat, err, q);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL misalign_half_err: got %b want 1", err); end
    access(0, 1, 2'b00, BASE + 32'h1FFC, 32'h0BAD_F00D, lat, err, q);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL top_word_err: got %b want 0", err); end
    access(1, 0, 2'b10, BASE + 32'h1FFF, 32'h0, lat, err, q);
    n_checks++; if (q !== 32'h0000_000B || err !== 1'b0) begin
      n_fail++; $display("FAIL top_byte_rd: got %h err %b want 0000000b err 0", q, err);
    end
  endtask

  task automatic test_handshake();
    int lat; logic err; logic [31:0] q;
    drive(1, 0, 2'b00, BASE, 32'h0);
    wait_ready(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (ready !== 1'b1 || dmem_data !== 32'hA5A5_A5A5) begin
        n_fail++; $display("FAIL hold_ready: cycle %0d ready %b data %h want 1 a5a5a5a5", i, ready, dmem_data);
      end
    end
    dmem_r = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL drop_ready: got %b want 0", ready); end
    access(1, 1, 2'b00, BASE + 32'h20, 32'h7777_8888, lat, err, q);
    n_checks++; if (lat !== 1 || q !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL rw_both: lat %0d data %h want 1 a5a5a5a5", lat, q);
    end
    access(1, 0, 2'b00, BASE + 32'h20, 32'h0, lat, err, q);
    n_checks++; if (q !== 32'h7777_8888) begin n_fail++; $display("FAIL rw_both_written: got %h want 77778888", q); end
  endtask

  task automatic test_reset_abort();
    int lat; logic err; logic [31:0] q;
    access(0, 1, 2'b00, BASE + 32'h30, 32'h5555_5555, lat, err, q);
    access(1, 0, 2'b00, BASE + 32'h30, 32'h0, lat, err, q);
    drive(0, 1, 2'b10, BASE + 32'h31, 32'h0000_00EE);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; dmem_w = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", ready); end
    n_checks++; if (dmem_data !== 32'h0) begin n_fail++; $display("FAIL abort_data: got %h want 0", dmem_data); end
    rst = 1'b0;
    access(1, 0, 2'b00, BASE + 32'h30, 32'h0, lat, err, q);
    n_checks++; if (q !== 32'h5555_5555) begin n_fail++; $display("FAIL abort_no_write: got %h want 55555555", q); end
  endtask

  task automatic test_random();
    logic [31:0] mm [16];
    logic [31:0] exp_q;
    int lat; logic err; logic [31:0] q;
    for (int i = 0; i < 16; i++) begin
      mm[i] = $urandom;
      access(0, 1, 2'b00, BASE + 32'h400 + 32'(4 * i), mm[i], lat, err, q);
    end
    access(1, 0, 2'b00, BASE + 32'h400, 32'h0, lat, err, q);
    exp_q = mm[0];
    for (int n = 0; n < 80; n++) begin
      int op, f, fn, wi, lane, exp_lat;
      bit is_wr, exp_err;
      logic [31:0] d;
      op = $urandom_range(0, 2); f = $urandom_range(0, 3);
      wi = $urandom_range(0, 15); lane = $urandom_range(0, 3); d = $urandom;
      fn = (f == 3) ? 0 : f;
      is_wr = (op != 0);
      exp_err = ((fn == 0) && (lane != 0)) || ((fn == 1) && (lane % 2 == 1));
      exp_lat = exp_err ? 1 : (is_wr ? ((fn == 0) ? 1 : 3) : 2);
      access(op != 1, is_wr, 2'(f), BASE + 32'h400 + 32'(4 * wi + lane), d, lat, err, q);
      if (!exp_err && is_wr) mm[wi] = ref_store(mm[wi], fn, lane, d);
      if (!exp_err && !is_wr) exp_q = ref_load(mm[wi], fn, lane);
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", n, lat, exp_lat); end
      n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", n, err, exp_err); end
      n_checks++; if (q !== exp_q) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", n, q, exp_q); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_rmw();
    test_half_rmw();
    test_errors();
    test_handshake();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
